verin_bus_slave: RTL and testbench
==================================

# verin_bus_slave

Register-mapped responder for the actuator (vérin) control bus. The NIOS-side system drives this bus as the initiator through `address`/`chip_select`/`write_n`/`write_data` and samples `read_data`. The block decodes bus cycles into a register bank and generates the actuator PWM and direction. It also registers the tiller angle from the ADC and applies end-stop (butée) limits that cut drive when travel reaches a configured boundary.

## Interface

**Parameters**
- `CNT_W`, default 16: PWM frequency/duty register and counter width.
- `ANGLE_W`, default 12: angle and butée width.

**Ports**
- `clk` in 1: system clock. One clock domain only.
- `raz_n` in 1: reset. Asynchronous, active-low.
- `address` in 3: register select.
- `chip_select` in 1: bus cycle valid, active-high.
- `write_n` in 1: 0 = write, 1 = read. Only meaningful while `chip_select`=1.
- `write_data` in 32: write payload.
- `read_data` out 32: registered read payload.
- `angle_barre` in ANGLE_W: unsigned tiller angle from the ADC.
- `pwm_out` out 1: actuator drive.
- `sens` out 1: direction. 0 = towards left butée, 1 = towards right butée.
- `fin_butee` out 2: bit0 = left stop reached, bit1 = right stop reached.

## Operation

**Register map** (word addresses; unused write bits ignored; unused read bits return 0)
- 0 FREQ (RW): PWM period in clk ticks, bits[CNT_W-1:0].
- 1 DUTY (RW): high time in ticks, bits[CNT_W-1:0].
- 2 CTRL (RW): bit0 = enable, bit1 = sens.
- 3 BUTEE_G (RW): left limit.
- 4 BUTEE_D (RW): right limit.
- 5 STATUS (RO): bits[1:0] = fin_butee; bit2 = pwm_out; bits[27:16] = registered angle.
- 6 ANGLE (RO): registered angle, bits[ANGLE_W-1:0].
- 7: reserved. Reads 0; writes ignored.

**Bus cycles**
- Write: `chip_select`=1 and `write_n`=0 at a rising edge.
- Writes to addresses 5–7 have no effect.

**PWM** (sub-module)
- Counter runs 0..FREQ_sh−1, then wraps to 0.
- FREQ and DUTY are copied into shadow registers (FREQ_sh, DUTY_sh) only at wrap, or when the counter is idle. No mid-period glitch.
- Raw PWM = (counter < DUTY_sh).
- FREQ_sh < 2: counter held at 0 and raw PWM = 0.
- DUTY_sh ≥ FREQ_sh: raw PWM constantly 1.
- DUTY_sh = 0: raw PWM constantly 0.

**End-stop logic**
- `angle_r` ← `angle_barre` every cycle.
- `fin_butee[0]` ← (`angle_r` ≤ BUTEE_G).
- `fin_butee[1]` ← (`angle_r` ≥ BUTEE_D).
- Both bits may be 1 at the same time (misconfigured limits). Drive is then blocked in both directions.

**Output gating**
- `pwm_out` = raw PWM AND enable AND NOT (`sens`=0 AND `fin_butee[0]`) AND NOT (`sens`=1 AND `fin_butee[1]`).
- `pwm_out` is registered.
- `sens` output = CTRL.bit1, registered.

**Reset values** (all asynchronous on `raz_n`=0)
- FREQ = 0, DUTY = 0, CTRL = 0, BUTEE_G = 0, BUTEE_D = 2^ANGLE_W−1.
- Counter = 0, shadows = 0, `angle_r` = 0.
- `fin_butee` = 0, `pwm_out` = 0, `sens` = 0, `read_data` = 0.
- Reset mid-period kills the output immediately and asynchronously.

## Timing

- A write at edge N is visible in the register at edge N.
- FREQ/DUTY changes reach the counter at the first wrap after N.
- A CTRL write affects `pwm_out` and `sens` at edge N+1.
- Read: `read_data` is loaded at edge N when `chip_select`=1 and `write_n`=1 (latency 1). Otherwise it holds its last value.
- Read-during-write to the same address in consecutive cycles returns the new value.
- `angle_barre` change at edge N:
  - `angle_r` updates at N.
  - `fin_butee` updates at N+1.
  - `pwm_out` is gated at N+2.
- Throughput: one bus cycle per clock. No wait states.

## Structure

- Package `verin_pkg`:
  - address constants ADDR_FREQ … ADDR_ANGLE;
  - CTRL bit indices;
  - default widths;
  - BUTEE_D reset constant.
- Sub-module `pwm_gen`:
  - inputs: clk, raz_n, freq, duty;
  - output: raw pwm;
  - contains the counter and the shadow registers.
- Top level contains: bus decode, register bank, angle register, comparators, output gating.

## Test plan

- **Reset values**: assert `raz_n`=0 mid-operation → all outputs 0 immediately. Read BUTEE_D after release → 0x00000FFF.
- **PWM waveform**: write FREQ=10, DUTY=3, CTRL=0x1 → `pwm_out` high 3 / low 7 clocks, repeating. Period starts after the first wrap.
- **Glitch-free duty change**: write DUTY=7 mid-period → current period keeps 3 high clocks; next period has 7. DUTY=12 → constant 1. FREQ=1 → constant 0.
- **Left end-stop**: BUTEE_G=100, sens=0, `angle_barre` steps 150→100 → `fin_butee`=01 two clocks later and `pwm_out`=0. Set sens=1 → PWM resumes.
- **Right end-stop / overlap**: BUTEE_D=3000, angle 3000 → `fin_butee`=10, sens=1 blocked. BUTEE_G=3500 with angle 3000 → `fin_butee`=11, drive blocked in both directions.
- **Read-back**:
  - read each RW register → written value masked to width, latency 1 clock;
  - STATUS read → `{angle, pwm, fin_butee}` packed as specified;
  - write to address 6 → ignored;
  - read address 7 → 0.

Source files
------------

// File: rtl/verin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : verin_pkg
// Description : Shared constants for the actuator (verin) bus responder:
//               register word addresses, CTRL bit positions, default widths
//               and the reset value of the right end-stop limit.
// Revision    : 1.0 - initial release
// ============================================================================
package verin_pkg;

    // Default widths of the PWM counter and of the angle / end-stop values.
    localparam int c_cnt_w_def   = 16;
    localparam int c_angle_w_def = 12;

    // Register word addresses.
    localparam logic [2:0] c_addr_freq    = 3'd0;
    localparam logic [2:0] c_addr_duty    = 3'd1;
    localparam logic [2:0] c_addr_ctrl    = 3'd2;
    localparam logic [2:0] c_addr_butee_g = 3'd3;
    localparam logic [2:0] c_addr_butee_d = 3'd4;
    localparam logic [2:0] c_addr_status  = 3'd5;
    localparam logic [2:0] c_addr_angle   = 3'd6;

    // CTRL register bit positions.
    localparam int c_ctrl_enable = 0;
    localparam int c_ctrl_sens   = 1;

    // Right limit resets to full scale so the right stop is not reached
    // out of reset: all ones over the angle width.
    function automatic logic [31:0] butee_d_rst(input int width);
        return (32'h1 << width) - 32'h1;
    endfunction

endpackage : verin_pkg
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen
// Description : Free-running PWM generator. The period and high time are
//               taken from shadow copies that are refreshed only when a
//               period ends or when the generator is idle, so a change of
//               FREQ/DUTY never cuts a period short.
// Ports       : clk   - system clock
//               raz_n - asynchronous active-low reset
//               freq  - requested period in clk ticks
//               duty  - requested high time in clk ticks
//               pwm   - raw (ungated, combinational) PWM level
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             raz_n,
    input  logic [CNT_W-1:0] freq,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_freq_sh;
    logic [CNT_W-1:0] r_duty_sh;

    logic w_idle;
    logic w_wrap;
    logic w_reload;

    // A period shorter than two ticks cannot carry a pulse: counter parked.
    assign w_idle   = (r_freq_sh < CNT_W'(2));
    // Compared with >= so a counter can never run past the period.
    assign w_wrap   = (r_cnt >= (r_freq_sh - CNT_W'(1)));
    assign w_reload = w_idle | w_wrap;

    always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            r_cnt     <= '0;
            r_freq_sh <= '0;
            r_duty_sh <= '0;
        end else if (w_reload) begin
            r_cnt     <= '0;
            r_freq_sh <= freq;
            r_duty_sh <= duty;
        end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // DUTY >= FREQ gives a constant high naturally since r_cnt < FREQ.
    assign pwm = ~w_idle & (r_cnt < r_duty_sh);

endmodule : pwm_gen
`default_nettype wire

// File: rtl/verin_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : verin_bus_slave
// Description : Register-mapped responder on the actuator control bus.
//               Decodes single-cycle bus writes/reads into a register bank,
//               drives the actuator PWM and direction, registers the tiller
//               angle and cuts drive when an end-stop limit is reached.
// Ports       : clk          - system clock
//               raz_n        - asynchronous active-low reset
//               address      - register word address
//               chip_select  - bus cycle valid
//               write_n      - 0 = write, 1 = read
//               write_data   - write payload
//               read_data    - registered read payload (latency 1)
//               angle_barre  - unsigned tiller angle from the ADC
//               pwm_out      - gated, registered actuator drive
//               sens         - registered direction (0 left, 1 right)
//               fin_butee    - bit0 left stop reached, bit1 right stop
// Revision    : 1.0 - initial release
// ============================================================================
module verin_bus_slave
    import verin_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w_def,
    parameter int ANGLE_W = c_angle_w_def
) (
    input  logic               clk,
    input  logic               raz_n,
    input  logic [2:0]         address,
    input  logic               chip_select,
    input  logic               write_n,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    input  logic [ANGLE_W-1:0] angle_barre,
    output logic               pwm_out,
    output logic               sens,
    output logic [1:0]         fin_butee
);

    localparam logic [31:0] c_butee_d_rst = butee_d_rst(ANGLE_W);

    logic [CNT_W-1:0]   r_freq;
    logic [CNT_W-1:0]   r_duty;
    logic [1:0]         r_ctrl;
    logic [ANGLE_W-1:0] r_butee_g;
    logic [ANGLE_W-1:0] r_butee_d;
    logic [ANGLE_W-1:0] r_angle;
    logic [1:0]         r_fin_butee;
    logic               r_pwm_out;
    logic               r_sens;
    logic [31:0]        r_read_data;

    logic        w_wr;
    logic        w_rd;
    logic        w_pwm_raw;
    logic        w_block;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_wr = chip_select & ~write_n;
    assign w_rd = chip_select &  write_n;

    // Only the low bits of each write are kept; the rest is don't-care.
    assign w_unused_bits = ^write_data;

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            r_freq    <= '0;
            r_duty    <= '0;
            r_ctrl    <= '0;
            r_butee_g <= '0;
            r_butee_d <= c_butee_d_rst[ANGLE_W-1:0];
        end else if (w_wr) begin
            case (address)
                c_addr_freq:    r_freq    <= write_data[CNT_W-1:0];
                c_addr_duty:    r_duty    <= write_data[CNT_W-1:0];
                c_addr_ctrl:    r_ctrl    <= write_data[1:0];
                c_addr_butee_g: r_butee_g <= write_data[ANGLE_W-1:0];
                c_addr_butee_d: r_butee_d <= write_data[ANGLE_W-1:0];
                default: ;  // STATUS, ANGLE and reserved are read-only
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path: registers are read as they stand before the edge, so a
    // write followed by a read of the same address returns the new value.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (address)
            c_addr_freq:    w_rdata[CNT_W-1:0]   = r_freq;
            c_addr_duty:    w_rdata[CNT_W-1:0]   = r_duty;
            c_addr_ctrl:    w_rdata[1:0]         = r_ctrl;
            c_addr_butee_g: w_rdata[ANGLE_W-1:0] = r_butee_g;
            c_addr_butee_d: w_rdata[ANGLE_W-1:0] = r_butee_d;
            c_addr_status: begin
                // Angle field starts at bit 16 (bits 27:16 at 12 bits).
                w_rdata[1:0]           = r_fin_butee;
                w_rdata[2]             = r_pwm_out;
                w_rdata[16 +: ANGLE_W] = r_angle;
            end
            c_addr_angle:   w_rdata[ANGLE_W-1:0] = r_angle;
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            r_read_data <= '0;
        end else if (w_rd) begin
            r_read_data <= w_rdata;
        end
    end

    // ------------------------------------------------------------------
    // PWM core
    // ------------------------------------------------------------------
    pwm_gen #(
        .CNT_W (CNT_W)
    ) u_pwm_gen (
        .clk   (clk),
        .raz_n (raz_n),
        .freq  (r_freq),
        .duty  (r_duty),
        .pwm   (w_pwm_raw)
    );

    // ------------------------------------------------------------------
    // Angle capture and end-stop detection (one stage each)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            r_angle     <= '0;
            r_fin_butee <= '0;
        end else begin
            r_angle        <= angle_barre;
            r_fin_butee[0] <= (r_angle <= r_butee_g);
            r_fin_butee[1] <= (r_angle >= r_butee_d);
        end
    end

    // ------------------------------------------------------------------
    // Output gating: drive is cut only towards the stop that is reached;
    // with both stops flagged, both directions are blocked.
    // ------------------------------------------------------------------
    assign w_block = (~r_ctrl[c_ctrl_sens] & r_fin_butee[0]) |
                     ( r_ctrl[c_ctrl_sens] & r_fin_butee[1]);

    always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            r_pwm_out <= 1'b0;
            r_sens    <= 1'b0;
        end else begin
            r_pwm_out <= w_pwm_raw & r_ctrl[c_ctrl_enable] & ~w_block;
            r_sens    <= r_ctrl[c_ctrl_sens];
        end
    end

    assign read_data = r_read_data;
    assign pwm_out   = r_pwm_out;
    assign sens      = r_sens;
    assign fin_butee = r_fin_butee;

endmodule : verin_bus_slave
`default_nettype wire

// File: tb/tb_verin_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_verin_bus_slave
// Description : Self-checking bench for verin_bus_slave. A register-level
//               model of the block runs alongside the DUT and every output
//               is compared on each falling edge; directed scenarios add
//               literal expectations (pulse widths, limits, read-back).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_verin_bus_slave;

    logic        clk = 1'b0;
    logic        raz_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chip_select = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [11:0] angle_barre = 12'd2000;
    logic        pwm_out;
    logic        sens;
    logic [1:0]  fin_butee;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    verin_bus_slave #(
        .CNT_W   (16),
        .ANGLE_W (12)
    ) dut (
        .clk         (clk),
        .raz_n       (raz_n),
        .address     (address),
        .chip_select (chip_select),
        .write_n     (write_n),
        .write_data  (write_data),
        .read_data   (read_data),
        .angle_barre (angle_barre),
        .pwm_out     (pwm_out),
        .sens        (sens),
        .fin_butee   (fin_butee)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: register values plus one PWM period position.
    // ------------------------------------------------------------------
    int   m_freq, m_duty, m_bg, m_bd, m_angle;
    int   m_pos, m_per, m_high;       // position in period, live period/high
    logic m_en, m_dir;
    logic m_left, m_right;
    logic m_pwm, m_sens;
    logic [31:0] m_rd;
    logic m_raw;
    logic m_drive_ok;

    always_comb begin
        m_raw      = (m_per >= 2) && (m_pos < m_high);
        m_drive_ok = m_dir ? !m_right : !m_left;
    end

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_freq);
            3'd1: return 32'(m_duty);
            3'd2: return {30'd0, m_dir, m_en};
            3'd3: return 32'(m_bg);
            3'd4: return 32'(m_bd);
            3'd5: return (32'(m_angle) << 16) | {29'd0, m_pwm, m_right, m_left};
            3'd6: return 32'(m_angle);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
            m_freq <= 0; m_duty <= 0; m_bg <= 0; m_bd <= 4095; m_angle <= 0;
            m_pos <= 0; m_per <= 0; m_high <= 0;
            m_en <= 1'b0; m_dir <= 1'b0; m_left <= 1'b0; m_right <= 1'b0;
            m_pwm <= 1'b0; m_sens <= 1'b0; m_rd <= '0;
        end else begin
            if (chip_select && !write_n) begin
                case (address)
                    3'd0: m_freq <= int'(write_data & 32'hFFFF);
                    3'd1: m_duty <= int'(write_data & 32'hFFFF);
                    3'd2: begin m_en <= write_data[0]; m_dir <= write_data[1]; end
                    3'd3: m_bg <= int'(write_data & 32'hFFF);
                    3'd4: m_bd <= int'(write_data & 32'hFFF);
                    default: ;
                endcase
            end
            if (chip_select && write_n) m_rd <= m_read(address);
            // End of a period (or nothing running): start over with the
            // currently programmed settings.
            if (m_per < 2 || m_pos == m_per - 1) begin
                m_pos <= 0; m_per <= m_freq; m_high <= m_duty;
            end else begin
                m_pos <= m_pos + 1;
            end
            m_angle <= int'(angle_barre);
            m_left  <= (m_angle <= m_bg);
            m_right <= (m_angle >= m_bd);
            m_pwm   <= m_raw && m_en && m_drive_ok;
            m_sens  <= m_dir;
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (raz_n) begin
            check("pwm_out_vs_model",   {31'd0, pwm_out}, {31'd0, m_pwm});
            check("sens_vs_model",      {31'd0, sens},    {31'd0, m_sens});
            check("fin_butee_vs_model", {30'd0, fin_butee}, {30'd0, m_right, m_left});
            check("read_data_vs_model", read_data, m_rd);
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers: each is entered and left on a falling edge.
    // ------------------------------------------------------------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chip_select = 1'b1; write_n = 1'b0; address = a; write_data = d;
        @(negedge clk);
        chip_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        chip_select = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chip_select = 1'b0;
        d = read_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            if (pwm_out) h++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(input string name);
        int k = 0;
        while (pwm_out !== 1'b1 && k < 60) begin
            k++;
            @(negedge clk);
        end
        if (k >= 60) check(name, 32'd0, 32'd1);
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (pwm_out === v && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        int n;
        int h;

        // Reset release and reset-state checks.
        #23;
        @(negedge clk);
        raz_n = 1'b1;
        check("rst_pwm_out",   {31'd0, pwm_out}, 32'd0);
        check("rst_sens",      {31'd0, sens}, 32'd0);
        check("rst_fin_butee", {30'd0, fin_butee}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        rd(3'd4, d);
        check("rst_butee_d", d, 32'h0000_0FFF);

        // PWM waveform: 3 high / 7 low.
        wr(3'd0, 32'd10);
        wr(3'd1, 32'd3);
        wr(3'd2, 32'h1);
        wait_rise("rise1_timeout");
        run_len(1'b1, n); check("pwm_high_3", 32'(n), 32'd3);
        run_len(1'b0, n); check("pwm_low_7",  32'(n), 32'd7);

        // Glitch-free duty change in the middle of a high phase.
        wait_rise("rise2_timeout");
        wr(3'd1, 32'd7);
        run_len(1'b1, n); check("duty_chg_cur_high", 32'(n + 1), 32'd3);
        run_len(1'b0, n); check("duty_chg_cur_low",  32'(n), 32'd7);
        run_len(1'b1, n); check("duty_chg_next_high", 32'(n), 32'd7);
        run_len(1'b0, n); check("duty_chg_next_low",  32'(n), 32'd3);

        // DUTY above FREQ: constant high.
        wr(3'd1, 32'd12);
        idle(15);
        count_high(10, h); check("duty_ge_freq_const1", 32'(h), 32'd10);

        // FREQ below 2: constant low.
        wr(3'd0, 32'd1);
        idle(25);
        count_high(10, h); check("freq_lt2_const0", 32'(h), 32'd0);
        wr(3'd0, 32'd10);
        wr(3'd1, 32'd3);
        idle(25);

        // Left end-stop.
        wr(3'd3, 32'd100);
        angle_barre = 12'd150;
        idle(3);
        angle_barre = 12'd100;
        idle(2);
        check("left_stop_fin", {30'd0, fin_butee}, 32'h1);
        idle(1);
        count_high(12, h); check("left_stop_blocked", 32'(h), 32'd0);
        wr(3'd2, 32'h3);
        idle(2);
        check("sens_right", {31'd0, sens}, 32'd1);
        count_high(10, h); check("left_stop_sens1_runs", 32'(h), 32'd3);

        // Right end-stop, then overlapping limits.
        angle_barre = 12'd3000;
        wr(3'd4, 32'd3000);
        idle(3);
        check("right_stop_fin", {30'd0, fin_butee}, 32'h2);
        count_high(10, h); check("right_stop_blocked", 32'(h), 32'd0);
        wr(3'd2, 32'h1);
        idle(2);
        count_high(10, h); check("right_stop_sens0_runs", 32'(h), 32'd3);
        wr(3'd3, 32'd3500);
        idle(3);
        check("overlap_fin", {30'd0, fin_butee}, 32'h3);
        count_high(10, h); check("overlap_sens0_blocked", 32'(h), 32'd0);
        wr(3'd2, 32'h3);
        idle(2);
        count_high(10, h); check("overlap_sens1_blocked", 32'(h), 32'd0);

        // Read-back.
        rd(3'd0, d); check("rb_freq", d, 32'd10);
        rd(3'd1, d); check("rb_duty", d, 32'd3);
        wr(3'd0, 32'hABCD_1234);
        rd(3'd0, d); check("rb_freq_masked", d, 32'h0000_1234);
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, d); check("rb_ctrl_masked", d, 32'h3);
        wr(3'd3, 32'hFFFF_F123);
        rd(3'd3, d); check("rb_butee_g_masked", d, 32'h123);
        rd(3'd4, d); check("rb_butee_d", d, 32'hBB8);
        wr(3'd1, 32'd5);
        rd(3'd1, d); check("rb_rdw_duty", d, 32'd5);
        idle(3);
        rd(3'd5, d); check("rb_status", d, 32'h0BB8_0002);
        rd(3'd6, d); check("rb_angle", d, 32'hBB8);
        wr(3'd6, 32'h55);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd6, d); check("rb_angle_wr_ignored", d, 32'hBB8);
        rd(3'd5, d); check("rb_status_wr_ignored", d, 32'h0BB8_0002);
        rd(3'd7, d); check("rb_reserved", d, 32'd0);

        // Asynchronous reset during a constant-high drive.
        wr(3'd0, 32'd10);
        wr(3'd1, 32'd12);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'h1);
        idle(4700);
        rd(3'd0, d); check("pre_rst_freq", d, 32'd10);
        check("pre_rst_pwm_high", {31'd0, pwm_out}, 32'd1);
        #2;
        raz_n = 1'b0;
        #1;
        check("async_rst_pwm_out",   {31'd0, pwm_out}, 32'd0);
        check("async_rst_sens",      {31'd0, sens}, 32'd0);
        check("async_rst_fin_butee", {30'd0, fin_butee}, 32'd0);
        check("async_rst_read_data", read_data, 32'd0);
        @(negedge clk);
        raz_n = 1'b1;
        rd(3'd4, d); check("post_rst_butee_d", d, 32'h0000_0FFF);
        rd(3'd0, d); check("post_rst_freq", d, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_verin_bus_slave
`default_nettype wire
